// File: rtl/plot_pkg.sv
// Shared types and constants for the plot sink: screen geometry, FIFO depth,
// the pixel record carried through the FIFO, the controller state encoding,
// and the shift-and-add framebuffer address helper.
package plot_pkg;

    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned FB_WORDS   = 19200;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // y*160 + x as (y<<7)+(y<<5)+x, kept to 15 bits so the result wraps.
    function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] y15;
        y15 = {8'd0, y};
        return (y15 << 7) + (y15 << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// First-word-fall-through pixel FIFO. The head entry is visible on o_head
// whenever o_empty is low; a push on full or a pop on empty is ignored.
module plot_fifo
    import plot_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_push,
    input  pixel_t i_data,
    input  logic   i_pop,
    output pixel_t o_head,
    output logic   o_full,
    output logic   o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    pixel_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == (PW+1)'(0));
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= (PW+1)'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/plot_sink.sv
// Pixel sink between a drawing engine and a 160x120 framebuffer. Buffers
// plotted pixels in a small FIFO and can fill the whole screen on request.
// Optional build macro PLOT_CLIP_EN discards off-screen pixels and counts them.
module plot_sink
    import plot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    output logic        in_ready,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    output logic        clear_done,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_wdata,
    output logic        fb_we,
    input  logic        fb_wready,
    output logic [7:0]  clip_count
);

    state_t      r_state;
    logic [14:0] r_fill_cnt;
    logic [2:0]  r_clear_colour;
    pixel_t      w_in_pixel;
    pixel_t      w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_off;
    logic        w_push;
    logic        w_pop;
    logic        w_write_done;

    assign w_in_pixel   = '{x: in_x, y: in_y, colour: in_colour};
    assign w_accept     = in_plot && in_ready;
    assign w_push       = w_accept && !w_off;
    assign w_write_done = fb_we && fb_wready;
    assign w_pop        = (r_state == ST_RUN) && w_write_done;
    assign clear_done   = rst_n && (r_state == ST_DONE);

`ifdef PLOT_CLIP_EN
    logic [7:0] r_clip_count;

    assign w_off      = (in_x >= 8'(SCREEN_W)) || (in_y >= 7'(SCREEN_H));
    assign clip_count = r_clip_count;

    // Saturating count of accepted pixels that fall outside the screen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clip_count <= 8'd0;
        end else if (w_accept && w_off && (r_clip_count != 8'hFF)) begin
            r_clip_count <= r_clip_count + 8'd1;
        end
    end
`else
    assign w_off      = 1'b0;
    assign clip_count = 8'd0;
`endif

    plot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_in_pixel),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Handshake and framebuffer drive; everything is forced quiet while in reset.
    always_comb begin
        in_ready = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = 15'd0;
        fb_wdata = 3'd0;
        if (!rst_n) begin
            in_ready = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    in_ready = !w_full && !clear_start;
                    fb_we    = !w_empty;
                    if (!w_empty) begin
                        fb_addr  = pixel_addr(w_head.x, w_head.y);
                        fb_wdata = w_head.colour;
                    end else begin
                        fb_addr  = 15'd0;
                    end
                end
                ST_CLEAR: begin
                    fb_we    = 1'b1;
                    fb_addr  = r_fill_cnt;
                    fb_wdata = r_clear_colour;
                end
                default: begin
                    fb_we    = 1'b0;
                end
            endcase
        end
    end

    // Controller: drain pending pixels, sweep the fill, then wait for the request to drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_fill_cnt     <= 15'd0;
            r_clear_colour <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (clear_start && w_empty) begin
                        r_state        <= ST_CLEAR;
                        r_clear_colour <= clear_colour;
                        r_fill_cnt     <= 15'd0;
                    end
                end
                ST_CLEAR: begin
                    if (w_write_done) begin
                        if (r_fill_cnt == 15'(FB_WORDS - 1)) begin
                            r_state    <= ST_DONE;
                            r_fill_cnt <= 15'd0;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 15'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!clear_start) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink: reset values, single plot, FIFO back-pressure,
// screen fill with pending pixels, reset during fill, and address/clip corners.
module tb_plot_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        clear_done;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic        fb_wready;
    logic [7:0]  clip_count;

    int errors = 0;
    int checks = 0;

    logic [14:0] log_addr [$];
    logic [2:0]  log_data [$];

    plot_sink dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_colour    (in_colour),
        .in_plot      (in_plot),
        .in_ready     (in_ready),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_we        (fb_we),
        .fb_wready    (fb_wready),
        .clip_count   (clip_count)
    );

    always #5 clk = ~clk;

    // Record every completed framebuffer write.
    always @(posedge clk) begin
        if (rst_n && fb_we && fb_wready) begin
            log_addr.push_back(fb_addr);
            log_data.push_back(fb_wdata);
        end
    end

    task automatic drive_pixel(input int x, input int y, input int c);
        in_x      = 8'(x);
        in_y      = 7'(y);
        in_colour = 3'(c);
        in_plot   = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_plot = 1'b0; in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0;
        clear_start = 1'b0; clear_colour = 3'd0; fb_wready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %0d expected 0", fb_we); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0d expected 0", in_ready); end
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %0d expected 0", clear_done); end
        checks++; if (fb_addr !== 15'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
        checks++; if (fb_wdata !== 3'd0) begin errors++; $display("FAIL reset_fb_wdata: got %0d expected 0", fb_wdata); end
        checks++; if (clip_count !== 8'd0) begin errors++; $display("FAIL reset_clip_count: got %0d expected 0", clip_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0d expected 1", in_ready); end
    endtask

    task automatic test_single;
        log_addr.delete(); log_data.delete();
        @(negedge clk);
        fb_wready = 1'b1;
        drive_pixel(10, 5, 3);
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_early: got %0d expected 0", fb_we); end
        @(negedge clk);
        in_plot = 1'b0;
        #1;
        checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL single_we: got %0d expected 1", fb_we); end
        checks++; if (fb_addr !== 15'd810) begin errors++; $display("FAIL single_addr: got %0d expected 810", fb_addr); end
        checks++; if (fb_wdata !== 3'd3) begin errors++; $display("FAIL single_data: got %0d expected 3", fb_wdata); end
        @(negedge clk); #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_after: got %0d expected 0", fb_we); end
        checks++; if (log_addr.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", log_addr.size()); end
    endtask

    task automatic test_back_to_back;
        int px [5] = '{1, 2, 3, 4, 5};
        int py [5] = '{0, 0, 1, 2, 3};
        int pc [5] = '{1, 2, 3, 4, 5};
        bit got_ready;
        int bad;
        log_addr.delete(); log_data.delete();
        fb_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_pixel(px[i], py[i], pc[i]);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0d expected 1", i, in_ready); end
        end
        @(negedge clk);
        drive_pixel(px[4], py[4], pc[4]);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %0d expected 0", in_ready); end
        fb_wready = 1'b1;
        got_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (in_ready === 1'b1) begin
                got_ready = 1'b1;
                break;
            end
        end
        checks++; if (!got_ready) begin errors++; $display("FAIL b2b_ready_timeout: got 0 expected 1"); end
        @(negedge clk);
        in_plot = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (log_addr.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", log_addr.size()); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < log_addr.size()) begin
                if (log_addr[i] !== 15'(py[i] * 160 + px[i]) || log_data[i] !== 3'(pc[i])) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order: got %0d bad writes expected 0", bad); end
    endtask

    task automatic test_clip;
`ifdef PLOT_CLIP_EN
        log_addr.delete(); log_data.delete();
        fb_wready = 1'b1;
        @(negedge clk);
        drive_pixel(160, 0, 2);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clip_ready: got %0d expected 1", in_ready); end
        @(negedge clk);
        drive_pixel(0, 120, 2);
        @(negedge clk);
        in_plot = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL clip_no_write: got %0d writes expected 0", log_addr.size()); end
        checks++; if (clip_count !== 8'd2) begin errors++; $display("FAIL clip_count2: got %0d expected 2", clip_count); end
        @(negedge clk);
        drive_pixel(200, 50, 1);
        repeat (300) @(negedge clk);
        in_plot = 1'b0;
        #1;
        checks++; if (clip_count !== 8'd255) begin errors++; $display("FAIL clip_saturate: got %0d expected 255", clip_count); end
`endif
    endtask

    task automatic test_corner;
        logic [7:0] exp_clip;
`ifdef PLOT_CLIP_EN
        exp_clip = 8'd255;
`else
        exp_clip = 8'd0;
`endif
        fb_wready = 1'b1;
        @(negedge clk);
        drive_pixel(159, 119, 6);
        @(negedge clk);
        in_plot = 1'b0;
        #1;
        checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL corner_we: got %0d expected 1", fb_we); end
        checks++; if (fb_addr !== 15'd19199) begin errors++; $display("FAIL corner_addr: got %0d expected 19199", fb_addr); end
        checks++; if (fb_wdata !== 3'd6) begin errors++; $display("FAIL corner_data: got %0d expected 6", fb_wdata); end
        checks++; if (clip_count !== exp_clip) begin errors++; $display("FAIL corner_clip: got %0d expected %0d", clip_count, exp_clip); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear;
        bit done_seen;
        int bad;
        log_addr.delete(); log_data.delete();
        fb_wready = 1'b0;
        @(negedge clk);
        drive_pixel(7, 1, 6);
        @(negedge clk);
        drive_pixel(8, 1, 7);
        @(negedge clk);
        in_plot = 1'b0;
        clear_start = 1'b1;
        clear_colour = 3'd1;
        fb_wready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_drain: got %0d expected 0", in_ready); end
        done_seen = 1'b0;
        for (int k = 0; k < 19400; k++) begin
            @(negedge clk); #1;
            if (k == 10) clear_colour = 3'd5;
            if (clear_done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
        end
        checks++; if (!done_seen) begin errors++; $display("FAIL clear_done_timeout: got 0 expected 1"); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL done_fb_we: got %0d expected 0", fb_we); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready: got %0d expected 0", in_ready); end
        checks++; if (log_addr.size() != 19202) begin errors++; $display("FAIL clear_count: got %0d expected 19202", log_addr.size()); end
        bad = 0;
        if (log_addr.size() == 19202) begin
            if (log_addr[0] !== 15'd167 || log_data[0] !== 3'd6) bad++;
            if (log_addr[1] !== 15'd168 || log_data[1] !== 3'd7) bad++;
            for (int i = 0; i < 19200; i++) begin
                if (log_addr[i+2] !== 15'(i) || log_data[i+2] !== 3'd1) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sequence: got %0d bad writes expected 0", bad); end
        @(negedge clk);
        clear_start = 1'b0;
        @(negedge clk); #1;
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL run_clear_done: got %0d expected 0", clear_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %0d expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_clear;
        bit hit;
        log_addr.delete(); log_data.delete();
        fb_wready = 1'b1;
        @(negedge clk);
        clear_colour = 3'd2;
        clear_start = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk); #1;
            if (fb_we === 1'b1 && fb_addr === 15'd5000) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_fill_timeout: got 0 expected 1"); end
        rst_n = 1'b0;
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %0d expected 0", fb_we); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_start = 1'b0;
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL after_rst_we: got %0d expected 0", fb_we); end
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL after_rst_done: got %0d expected 0", clear_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_rst_ready: got %0d expected 1", in_ready); end
        checks++; if (log_addr.size() != 5000) begin errors++; $display("FAIL mid_fill_writes: got %0d expected 5000", log_addr.size()); end
        repeat (3) @(negedge clk);
        checks++; if (log_addr.size() != 5000) begin errors++; $display("FAIL no_write_after_rst: got %0d expected 5000", log_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clip();
        test_corner();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Port clk  in  1  single clock, all state on rising edge.
REQ-002 Port rst_n  in  1  reset; synchronous and active-low.
REQ-003 Port in_x  in  8  pixel column from drawing engine.
REQ-004 Port in_y  in  7  pixel row from drawing engine.
REQ-005 Port in_colour  in  3  pixel colour.
REQ-006 Port in_plot  in  1  pixel valid; source holds x/y/colour/plot stable while in_ready low.
REQ-007 Port in_ready  out  1  sink can accept a pixel this cycle.
REQ-008 Port clear_start  in  1  level request to fill the whole screen with clear_colour.
REQ-009 Port clear_colour  in  3  fill colour, sampled on clear entry.
REQ-010 Port clear_done  out  1  fill complete.
REQ-011 Port fb_addr  out  15  framebuffer word address, y*160+x.
REQ-012 Port fb_wdata  out  3  framebuffer write colour.
REQ-013 Port fb_we  out  1  write request.
REQ-014 Port fb_wready  in  1  framebuffer accepts write; write completes on cycle fb_we && fb_wready.
REQ-015 Port clip_count  out  8  count of discarded off-screen pixels.

Function
REQ-016 States RUN, CLEAR, DONE; reset state RUN.
REQ-017 RUN: in_ready = !fifo_full && !clear_start; pixel pushed when in_plot && in_ready.
REQ-018 FIFO depth 4, first-word-fall-through; pixel accepted cycle N drives fb_we earliest cycle N+1.
REQ-019 RUN: fb_we = !fifo_empty; fb_addr/fb_wdata from FIFO head, held stable until fb_wready; pop on completion.
REQ-020 Address = (y<<7)+(y<<5)+x, computed in 15 bits, no multiplier.
REQ-021 Push and pop same cycle allowed; occupancy unchanged; push on full never occurs (in_ready low).
REQ-022 RUN -> CLEAR when clear_start high and FIFO empty; pending pixels drain first, no new pixels accepted meanwhile.
REQ-023 CLEAR: in_ready 0; clear_colour latched on entry; fb_we 1; addresses 0..19199 ascending, each held until fb_wready.
REQ-024 CLEAR -> DONE on completion of address 19199.
REQ-025 DONE: clear_done 1, fb_we 0, in_ready 0; DONE -> RUN when clear_start low.
REQ-026 clear_start dropping during CLEAR has no effect; fill always completes.
REQ-027 fb_we never asserted in DONE or reset cycle.

Reset
REQ-028 rst_n low: state RUN, FIFO empty, fill counter 0, clip_count 0, clear_done 0, fb_we 0, in_ready 0, fb_addr 0, fb_wdata 0.
REQ-029 Reset mid-CLEAR or with pending pixels aborts; pending pixels lost; no write after reset edge.

Configuration
REQ-030 Macro PLOT_CLIP_EN defined: pixel with x>=160 or y>=120 is accepted (handshake completes) but not pushed; clip_count increments, saturates at 255.
REQ-031 PLOT_CLIP_EN undefined: no range check, every accepted pixel pushed, address wraps modulo 2^15; clip_count tied 0.

Structure
REQ-032 Package plot_pkg holds SCREEN_W=160, SCREEN_H=120, FB_WORDS=19200, FIFO_DEPTH=4, pixel_t struct {x,y,colour}, state enum.
REQ-033 One sub-module plot_fifo (parameterised pixel_t FIFO, full/empty flags); FSM, address and fill logic in plot_sink.

Verification
REQ-034 Plot (10,5,c=3), fb_wready=1 -> next cycle fb_we=1, fb_addr=810, fb_wdata=3, single write.
REQ-035 fb_wready=0, stream 5 pixels -> in_ready drops after 4th; raise fb_wready -> 5 writes in input order, none lost or duplicated.
REQ-036 clear_start with 2 pending pixels, clear_colour=1 -> 2 pixel writes, then 19200 writes of 1 at addresses 0..19199, clear_done=1; drop clear_start -> RUN next cycle.
REQ-037 PLOT_CLIP_EN: plot (160,0) and (0,120) -> no fb_we, clip_count=2; 300 off-screen plots -> clip_count=255. Without macro: (159,119) -> fb_addr=19199.
REQ-038 rst_n low at fill address 5000 -> next cycle fb_we=0, state RUN, clear_done=0, FIFO empty.
